// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the configuration chain loader and the CB/SB/CLB tiles.
package cfg_chain_pkg;

  // Default chain length and host word width used across the tile family.
  localparam int CFG_CHAIN_LEN = 69;
  localparam int CFG_WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } cfg_state_e;

  // Number of host words needed to cover len chain bits.
  function automatic int words_for(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/cfg_rb_packer.sv
// Serial-to-parallel readback accumulator. Collects one bit per enabled chain
// edge, first-out bit at position 0, and flushes a word when it is full or when
// the final chain bit arrives (unfilled upper bits stay 0).
module cfg_rb_packer
#(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_i,
  input  logic              bit_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o
);
  localparam int PBW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [PBW-1:0] LAST_POS = PBW'(WORD_W - 1);

  logic [WORD_W-1:0] accum_q, accum_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [PBW-1:0]    pos_q, pos_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] merged;

  // Merge the sampled bit and decide whether this edge flushes a word.
  always_comb begin
    accum_d = accum_q;
    data_d  = data_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    merged  = accum_q | (WORD_W'(bit_i) << pos_q);
    if (sample_i) begin
      if (pos_q == LAST_POS || last_i) begin
        data_d  = merged;
        valid_d = 1'b1;
        accum_d = '0;
        pos_d   = '0;
      end else begin
        accum_d = merged;
        pos_d   = pos_q + 1'b1;
      end
    end
  end

  // Accumulator, bit position and output word registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accum_q <= '0;
      data_q  <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      accum_q <= accum_d;
      data_q  <= data_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Master end of the serial configuration chain: takes host words over a
// valid/ready stream, shifts them out LSB-first on prog_in/prog_en, and packs
// the bits returned on prog_out into readback words.
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int WORD_W    = CFG_WORD_W
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int WBW = $clog2(WORD_W + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN - 1);
  localparam logic [WBW-1:0] LAST_WBIT = WBW'(WORD_W - 1);

  cfg_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] word_shift;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WBW-1:0]    word_bit_q, word_bit_d;
  logic              prog_en_q, prog_en_d;
  logic              prog_in_q, prog_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Session sequencing: word fetch, bit shifting with last-bit prefetch, finish.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    word_bit_d = word_bit_q;
    prog_en_d  = prog_en_q;
    prog_in_d  = prog_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    // word_q holds the not-yet-driven bits with the currently driven bit at 0.
    word_shift = word_q >> 1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          word_bit_d = '0;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d    = SHIFT;
          word_d     = in_data;
          word_bit_d = '0;
          prog_en_d  = 1'b1;
          prog_in_d  = in_data[0];
        end
      end
      SHIFT: begin
        // Every edge in SHIFT delivers the bit currently on prog_in.
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = FINISH;
          prog_en_d = 1'b0;
          prog_in_d = 1'b0;
          done_d    = 1'b1;
        end else if (word_bit_q == LAST_WBIT) begin
          // Last bit of this word is on the wire: take the next word now so the
          // chain keeps shifting without a bubble, otherwise park in FETCH.
          in_ready   = 1'b1;
          word_bit_d = '0;
          if (in_valid) begin
            word_d    = in_data;
            prog_in_d = in_data[0];
          end else begin
            state_d   = FETCH;
            prog_en_d = 1'b0;
            prog_in_d = 1'b0;
          end
        end else begin
          word_bit_d = word_bit_q + 1'b1;
          word_d     = word_shift;
          prog_in_d  = word_shift[0];
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops prog_en immediately.
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      word_bit_q <= '0;
      prog_en_q  <= 1'b0;
      prog_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_cnt_q  <= bit_cnt_d;
      word_bit_q <= word_bit_d;
      prog_en_q  <= prog_en_d;
      prog_in_q  <= prog_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  cfg_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .clk_i    (prog_clk),
    .rst_ni   (rst),
    .sample_i (prog_en_q),
    .bit_i    (prog_out),
    .last_i   (bit_cnt_q == LAST_BIT),
    .data_o   (rb_data),
    .valid_o  (rb_valid)
  );

  assign prog_en = prog_en_q;
  assign prog_in = prog_in_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: a chain model feeds prog_out, expected
// readback words are queued by the stimulus and popped by a monitor.
module tb_cfg_chain_loader;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rb_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_tb;
  int   n_vec  = 0;
  int   n_fail = 0;

  // ---------------- main instance: 69 bits / 32-bit words ----------------
  logic        start, in_valid, in_ready, prog_in, prog_en, prog_out;
  logic [31:0] in_data, rb_data;
  logic        rb_valid, busy, done;

  cfg_chain_loader #(.CHAIN_LEN(69), .WORD_W(32)) dut (
    .prog_clk (clk),      .rst      (rst_n_tb),
    .start    (start),    .in_data  (in_data),
    .in_valid (in_valid), .in_ready (in_ready),
    .prog_in  (prog_in),  .prog_en  (prog_en),
    .prog_out (prog_out), .rb_data  (rb_data),
    .rb_valid (rb_valid), .busy     (busy),
    .done     (done)
  );

  // Chain model: shift toward bit 0, tail bit returns on prog_out.
  logic [68:0] chain;
  logic        preload_req = 1'b0;
  logic [68:0] preload_val = '0;
  int          sess_edges = 0;
  int          gap_cnt    = 0;
  int          done_cnt   = 0;
  rb_exp_t     exp_q[$];
  rb_exp_t     mon_e;

  assign prog_out = chain[0];

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (prog_en) chain <= {prog_in, chain[68:1]};
  end

  always @(posedge clk) begin
    if (!busy) begin
      sess_edges <= 0;
      gap_cnt    <= 0;
    end else if (prog_en) begin
      sess_edges <= sess_edges + 1;
    end else if (sess_edges > 0 && sess_edges < 69) begin
      gap_cnt <= gap_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare one expected readback word per rb_valid pulse.
  always @(negedge clk) begin
    if (rb_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rb_unexpected: got rb_data=0x%08h, required no pulse", rb_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("rb word: got 0x%08h done=%0b, expected 0x%08h done=%0b",
                 rb_data, done, mon_e.data, mon_e.last);
        check("rb_data", 69'(rb_data), 69'(mon_e.data));
        check("rb_last_with_done", 69'(done), 69'(mon_e.last));
      end
    end
    if (done) done_cnt++;
    if (!prog_en && prog_in) check("prog_in_zero_when_disabled", 69'(prog_in), 69'(0));
  end

  task automatic push_rb(input logic [31:0] d, input logic l);
    exp_q.push_back('{data: d, last: l});
  endtask

  task automatic preload(input logic [68:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // Present one word and hold it until the loader takes it.
  task automatic send_word(input logic [31:0] w, input string tag);
    int t;
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check({tag, "_handshake_timeout"}, 69'(in_ready), 69'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_session(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                             input int stall, input bit mid_start, input bit start_with_valid,
                             input logic [68:0] exp_chain, input string tag);
    int d0, t;
    d0 = done_cnt;
    if (start_with_valid) begin
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = w0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_word_not_taken_with_start"}, 69'(prog_en), 69'(0));
      check({tag, "_fetch_ready"}, 69'(in_ready), 69'(1));
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_word_taken_next_cycle"}, 69'(prog_en), 69'(1));
    end else begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, 69'(busy), 69'(1));
      send_word(w0, tag);
    end
    if (mid_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_word(w1, tag);
    if (stall > 0) begin
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      repeat (stall) @(negedge clk);
    end
    send_word(w2, tag);
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    $display("%s: done=%0b edges=%0d gap=%0d chain=0x%018h", tag, done, sess_edges, gap_cnt, chain);
    check({tag, "_done_seen"}, 69'(done), 69'(1));
    check({tag, "_enabled_edges"}, 69'(sess_edges), 69'(69));
    check({tag, "_stall_cycles"}, 69'(gap_cnt), 69'(stall));
    check({tag, "_chain"}, chain, exp_chain);
    repeat (3) @(negedge clk);
    check({tag, "_busy_cleared"}, 69'(busy), 69'(0));
    check({tag, "_done_pulses"}, 69'(done_cnt - d0), 69'(1));
    check({tag, "_rb_queue_drained"}, 69'(exp_q.size()), 69'(0));
  endtask

  // ---------------- small instances: 32/32 and 1/32 ----------------
  logic        b_start = 1'b0, b_in_valid = 1'b0, b_in_ready, b_prog_in, b_prog_en;
  logic [31:0] b_in_data = '0, b_rb_data;
  logic        b_rb_valid, b_busy, b_done, b_load = 1'b0;
  logic [31:0] b_chain;
  int          b_edges = 0;

  cfg_chain_loader #(.CHAIN_LEN(32), .WORD_W(32)) dut_b (
    .prog_clk (clk),        .rst      (rst_n_tb),
    .start    (b_start),    .in_data  (b_in_data),
    .in_valid (b_in_valid), .in_ready (b_in_ready),
    .prog_in  (b_prog_in),  .prog_en  (b_prog_en),
    .prog_out (b_chain[0]), .rb_data  (b_rb_data),
    .rb_valid (b_rb_valid), .busy     (b_busy),
    .done     (b_done)
  );

  always @(posedge clk) begin
    if (b_load) b_chain <= 32'hA5A5_0F0F;
    else if (b_prog_en) b_chain <= {b_prog_in, b_chain[31:1]};
    if (b_prog_en) b_edges <= b_edges + 1;
  end

  logic        c_start = 1'b0, c_in_valid = 1'b0, c_in_ready, c_prog_in, c_prog_en;
  logic [31:0] c_in_data = '0, c_rb_data;
  logic        c_rb_valid, c_busy, c_done, c_load = 1'b0;
  logic        c_chain;
  int          c_edges = 0;

  cfg_chain_loader #(.CHAIN_LEN(1), .WORD_W(32)) dut_c (
    .prog_clk (clk),        .rst      (rst_n_tb),
    .start    (c_start),    .in_data  (c_in_data),
    .in_valid (c_in_valid), .in_ready (c_in_ready),
    .prog_in  (c_prog_in),  .prog_en  (c_prog_en),
    .prog_out (c_chain),    .rb_data  (c_rb_data),
    .rb_valid (c_rb_valid), .busy     (c_busy),
    .done     (c_done)
  );

  always @(posedge clk) begin
    if (c_load) c_chain <= 1'b1;
    else if (c_prog_en) c_chain <= c_prog_in;
    if (c_prog_en) c_edges <= c_edges + 1;
  end

  // Single-bit chain session: program word w, expect readback rb_exp.
  task automatic c_session(input logic [31:0] w, input logic rb_exp, input logic chain_exp,
                           input int edges_exp, input string tag);
    int t;
    c_start = 1'b1;
    @(negedge clk);
    c_start    = 1'b0;
    c_in_data  = w;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    t = 0;
    while (!c_rb_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    $display("%s: rb_valid=%0b rb_data=0x%08h done=%0b chain=%0b edges=%0d",
             tag, c_rb_valid, c_rb_data, c_done, c_chain, c_edges);
    check({tag, "_rb_valid"}, 69'(c_rb_valid), 69'(1));
    check({tag, "_rb_data"}, 69'(c_rb_data), 69'(rb_exp));
    check({tag, "_done_with_rb"}, 69'(c_done), 69'(1));
    check({tag, "_chain"}, 69'(c_chain), 69'(chain_exp));
    check({tag, "_edges"}, 69'(c_edges), 69'(edges_exp));
    repeat (2) @(negedge clk);
  endtask

  localparam logic [68:0] IMG1 = {5'h1F, 32'h0123_4567, 32'h89AB_CDEF};
  localparam logic [68:0] IMG3 = {5'h0A, 32'h0F0F_0F0F, 32'hDEAD_BEEF};

  initial begin
    int t;
    rst_n_tb = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    // Reset state.
    check("reset_prog_en", 69'(prog_en), 69'(0));
    check("reset_prog_in", 69'(prog_in), 69'(0));
    check("reset_in_ready", 69'(in_ready), 69'(0));
    check("reset_rb_valid", 69'(rb_valid), 69'(0));
    check("reset_rb_data", 69'(rb_data), 69'(0));
    check("reset_busy", 69'(busy), 69'(0));
    check("reset_done", 69'(done), 69'(0));
    rst_n_tb = 1'b1;
    @(negedge clk);

    // 1: plain session over an all-zero chain.
    preload('0);
    push_rb(32'h0000_0000, 1'b0);
    push_rb(32'h0000_0000, 1'b0);
    push_rb(32'h0000_0000, 1'b1);
    run_session(32'h89AB_CDEF, 32'h0123_4567, 32'h0000_001F, 0, 1'b0, 1'b0, IMG1, "t1");

    // 2: readback of an all-ones chain.
    preload('1);
    push_rb(32'hFFFF_FFFF, 1'b0);
    push_rb(32'hFFFF_FFFF, 1'b0);
    push_rb(32'h0000_001F, 1'b1);
    run_session(32'h89AB_CDEF, 32'h0123_4567, 32'h0000_001F, 0, 1'b0, 1'b0, IMG1, "t2");

    // 3: five-cycle host stall before the third word; readback is image 1.
    push_rb(32'h89AB_CDEF, 1'b0);
    push_rb(32'h0123_4567, 1'b0);
    push_rb(32'h0000_001F, 1'b1);
    run_session(32'h89AB_CDEF, 32'h0123_4567, 32'h0000_001F, 5, 1'b0, 1'b0, IMG1, "t3");

    // 4: start together with in_valid, plus a start pulse mid-session.
    push_rb(32'h89AB_CDEF, 1'b0);
    push_rb(32'h0123_4567, 1'b0);
    push_rb(32'h0000_001F, 1'b1);
    run_session(32'h89AB_CDEF, 32'h0123_4567, 32'h0000_001F, 0, 1'b1, 1'b1, IMG1, "t4");

    // 5: reset after bit 40, then a fresh session.
    push_rb(32'h89AB_CDEF, 1'b0);
    t = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'hDEAD_BEEF, "t5a");
    send_word(32'h0F0F_0F0F, "t5a");
    while (sess_edges < 41 && busy) @(negedge clk);
    check("t5_edges_before_reset", 69'(sess_edges), 69'(41));
    #2 rst_n_tb = 1'b0;
    #1;
    check("t5_reset_prog_en", 69'(prog_en), 69'(0));
    check("t5_reset_busy", 69'(busy), 69'(0));
    check("t5_reset_in_ready", 69'(in_ready), 69'(0));
    check("t5_reset_done", 69'(done), 69'(0));
    repeat (2) @(negedge clk);
    rst_n_tb = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_no_done_pulse", 69'(done_cnt - t), 69'(0));
    check("t5_rb_queue", 69'(exp_q.size()), 69'(0));
    preload('1);
    push_rb(32'hFFFF_FFFF, 1'b0);
    push_rb(32'hFFFF_FFFF, 1'b0);
    push_rb(32'h0000_001F, 1'b1);
    run_session(32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'hFFFF_FFEA, 0, 1'b0, 1'b0, IMG3, "t5");

    // 6a: one-word chain.
    b_load = 1'b1;
    @(negedge clk);
    b_load  = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start    = 1'b0;
    b_in_data  = 32'h1234_5678;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    t = 0;
    while (!b_rb_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    $display("t6a: rb_valid=%0b rb_data=0x%08h done=%0b chain=0x%08h edges=%0d",
             b_rb_valid, b_rb_data, b_done, b_chain, b_edges);
    check("t6a_rb_valid", 69'(b_rb_valid), 69'(1));
    check("t6a_rb_data", 69'(b_rb_data), 69'(32'hA5A5_0F0F));
    check("t6a_done_with_rb", 69'(b_done), 69'(1));
    check("t6a_chain", 69'(b_chain), 69'(32'h1234_5678));
    check("t6a_edges", 69'(b_edges), 69'(32));
    repeat (2) @(negedge clk);

    // 6b: single-bit chain, two sessions.
    c_load = 1'b1;
    @(negedge clk);
    c_load = 1'b0;
    c_session(32'hFFFF_FFFE, 1'b1, 1'b0, 1, "t6b");
    c_session(32'h0000_0001, 1'b0, 1'b1, 2, "t6c");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
